// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle; Step_Req exists only with SINGLE_STEP_EN
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             BranchTK;
   logic             Reg_W_EN;
   logic [2:0]       Rd;
   logic [2:0]       Rs1;
   logic [2:0]       Rs2;
   logic             Halt_Req;
`ifdef SINGLE_STEP_EN
   logic             Step_Req;
`endif
   logic             PC_En;
   logic             IF2ID_Flush;
   logic             ID2EXE_Flush;
   logic             Fwd_A;
   logic             Fwd_B;
   logic             Halted;
   logic [CNT_W-1:0] Flush_Cnt;
   logic [CNT_W-1:0] Stall_Cnt;

   modport master (
`ifdef SINGLE_STEP_EN
      output Step_Req,
`endif
      output BranchTK, output Reg_W_EN, output Rd, output Rs1, output Rs2, output Halt_Req,
      input PC_En, input IF2ID_Flush, input ID2EXE_Flush, input Fwd_A, input Fwd_B,
      input Halted, input Flush_Cnt, input Stall_Cnt
   );

   modport slave (
`ifdef SINGLE_STEP_EN
      input Step_Req,
`endif
      input BranchTK, input Reg_W_EN, input Rd, input Rs1, input Rs2, input Halt_Req,
      output PC_En, output IF2ID_Flush, output ID2EXE_Flush, output Fwd_A, output Fwd_B,
      output Halted, output Flush_Cnt, output Stall_Cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline flush/stall/halt controller with forwarding; SINGLE_STEP_EN adds single-step
module pipe_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input logic        clk,
   input logic        Reset,
   pipe_ctrl_if.slave bus
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

`ifdef SINGLE_STEP_EN
   typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;
`else
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
`endif

   state_t           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] flush_cnt, stall_cnt;
   logic             pc_en, if2id_flush, id2exe_flush, halted;

`ifdef SINGLE_STEP_EN
   logic step_q;
   logic step_rise;
   assign step_rise = bus.Step_Req & ~step_q;
`endif

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      pc_en        = 1'b1;
      if2id_flush  = 1'b0;
      id2exe_flush = 1'b0;
      halted       = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.Halt_Req) begin
               pc_en       = 1'b0;
               if2id_flush = 1'b1;
               state_d     = DRAIN;
               drain_d     = DW'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            // the halting RUN cycle is the first bubble, so leave as the count hits zero
            pc_en       = 1'b0;
            if2id_flush = 1'b1;
            if (drain_q > DW'(1)) begin
               drain_d = drain_q - DW'(1);
            end else begin
               drain_d = '0;
               state_d = HALTED;
            end
         end
         HALTED: begin
            pc_en        = 1'b0;
            id2exe_flush = 1'b1;
            halted       = 1'b1;
            if (!bus.Halt_Req) begin
               state_d = RUN;
            end
`ifdef SINGLE_STEP_EN
            else if (step_rise) begin
               state_d = STEP;
            end
`endif
         end
`ifdef SINGLE_STEP_EN
         STEP: begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES - 1);
         end
`endif
         default: begin
            state_d = RUN;
            drain_d = '0;
         end
      endcase
      if (bus.BranchTK) begin
         if2id_flush  = 1'b1;
         id2exe_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         flush_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (bus.BranchTK && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
         if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

`ifdef SINGLE_STEP_EN
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         step_q <= 1'b0;
      end else begin
         step_q <= bus.Step_Req;
      end
   end
`endif

   assign bus.PC_En        = pc_en;
   assign bus.IF2ID_Flush  = if2id_flush;
   assign bus.ID2EXE_Flush = id2exe_flush;
   assign bus.Halted       = halted;
   assign bus.Flush_Cnt    = flush_cnt;
   assign bus.Stall_Cnt    = stall_cnt;
   assign bus.Fwd_A        = bus.Reg_W_EN && (bus.Rd == bus.Rs1) && (bus.Rd != 3'd0);
   assign bus.Fwd_B        = bus.Reg_W_EN && (bus.Rd == bus.Rs2) && (bus.Rd != 3'd0);
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed bench for pipe_ctrl; step checks build with SINGLE_STEP_EN
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   pipe_ctrl_if #(.CNT_W(16)) bus ();
   pipe_ctrl_if #(.CNT_W(4))  bus4 ();

   pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (.clk(clk), .Reset(rst), .bus(bus));
   pipe_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4))  dut4 (.clk(clk), .Reset(rst), .bus(bus4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.BranchTK = 0; bus.Reg_W_EN = 0; bus.Rd = 0; bus.Rs1 = 0; bus.Rs2 = 0; bus.Halt_Req = 0;
      bus4.BranchTK = 0; bus4.Reg_W_EN = 0; bus4.Rd = 0; bus4.Rs1 = 0; bus4.Rs2 = 0; bus4.Halt_Req = 0;
`ifdef SINGLE_STEP_EN
      bus.Step_Req = 0; bus4.Step_Req = 0;
`endif
      #1 rst = 1'b1;
      #2;
      chk("rst_pc_en", bus.PC_En, 1);
      chk("rst_if2id", bus.IF2ID_Flush, 0);
      chk("rst_id2exe", bus.ID2EXE_Flush, 0);
      chk("rst_halted", bus.Halted, 0);
      chk("rst_fwd", {bus.Fwd_A, bus.Fwd_B}, 0);
      chk("rst_flush_cnt", bus.Flush_Cnt, 0);
      chk("rst_stall_cnt", bus.Stall_Cnt, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // one-cycle branch in RUN
      bus.BranchTK = 1; #1;
      chk("br_if2id", bus.IF2ID_Flush, 1);
      chk("br_id2exe", bus.ID2EXE_Flush, 1);
      chk("br_pc_en", bus.PC_En, 1);
      chk("br_cnt_before", bus.Flush_Cnt, 0);
      tick();
      bus.BranchTK = 0; #1;
      chk("br_after_flush", {bus.IF2ID_Flush, bus.ID2EXE_Flush}, 0);
      chk("br_cnt_after", bus.Flush_Cnt, 1);
      chk("br_pc_en_after", bus.PC_En, 1);
      chk("br_stall_cnt", bus.Stall_Cnt, 0);

      // forwarding
      bus.Reg_W_EN = 1; bus.Rd = 3; bus.Rs1 = 3; bus.Rs2 = 0; #1;
      chk("fwd_rd3", {bus.Fwd_A, bus.Fwd_B}, 2'b10);
      bus.Rd = 0; bus.Rs1 = 0; bus.Rs2 = 0; #1;
      chk("fwd_rd0", {bus.Fwd_A, bus.Fwd_B}, 2'b00);
      bus.Rd = 5; bus.Rs1 = 2; bus.Rs2 = 5; #1;
      chk("fwd_b_only", {bus.Fwd_A, bus.Fwd_B}, 2'b01);
      bus.Rs1 = 5; #1;
      chk("fwd_both", {bus.Fwd_A, bus.Fwd_B}, 2'b11);
      bus.Reg_W_EN = 0; #1;
      chk("fwd_no_wen", {bus.Fwd_A, bus.Fwd_B}, 2'b00);
      bus.Rd = 0; bus.Rs1 = 0; bus.Rs2 = 0;
      tick();

      // halt held from cycle 0
      bus.Halt_Req = 1; #1;
      chk("h0_pc_en", bus.PC_En, 0);
      chk("h0_if2id", bus.IF2ID_Flush, 1);
      chk("h0_id2exe", bus.ID2EXE_Flush, 0);
      chk("h0_halted", bus.Halted, 0);
      tick();
      chk("h1_pc_en", bus.PC_En, 0);
      chk("h1_if2id", bus.IF2ID_Flush, 1);
      chk("h1_halted", bus.Halted, 0);
      tick();
      chk("h2_halted", bus.Halted, 1);
      chk("h2_pc_en", bus.PC_En, 0);
      chk("h2_id2exe", bus.ID2EXE_Flush, 1);
      chk("h2_if2id", bus.IF2ID_Flush, 0);
      chk("h2_stall_cnt", bus.Stall_Cnt, 2);
      tick();
      chk("h3_stall_cnt", bus.Stall_Cnt, 3);
      chk("h3_halted", bus.Halted, 1);
      bus.Halt_Req = 0; #1;
      chk("h3_pc_en_drop", bus.PC_En, 0);
      tick();
      chk("h4_pc_en", bus.PC_En, 1);
      chk("h4_halted", bus.Halted, 0);
      chk("h4_stall_cnt", bus.Stall_Cnt, 4);

      // halt dropped and branch taken mid-drain: no restart, no extension
      bus.Halt_Req = 1;
      tick();
      bus.Halt_Req = 0; bus.BranchTK = 1; #1;
      chk("d1_flushes", {bus.IF2ID_Flush, bus.ID2EXE_Flush}, 2'b11);
      chk("d1_pc_en", bus.PC_En, 0);
      tick();
      bus.BranchTK = 0; #1;
      chk("d2_halted", bus.Halted, 1);
      chk("d2_flush_cnt", bus.Flush_Cnt, 2);
      tick();
      chk("d3_pc_en", bus.PC_En, 1);
      chk("d3_stall_cnt", bus.Stall_Cnt, 7);

      // branch plus halt together, then reset in the first drain cycle
      bus.Halt_Req = 1; bus.BranchTK = 1; #1;
      chk("bh_flushes", {bus.IF2ID_Flush, bus.ID2EXE_Flush}, 2'b11);
      chk("bh_pc_en", bus.PC_En, 0);
      tick();
      bus.BranchTK = 0; bus.Halt_Req = 0; #1;
      chk("bh_drain_pc_en", bus.PC_En, 0);
      chk("bh_drain_halted", bus.Halted, 0);
      chk("bh_flush_cnt", bus.Flush_Cnt, 3);
      rst = 1'b1; #1;
      chk("rd_pc_en", bus.PC_En, 1);
      chk("rd_flush_cnt", bus.Flush_Cnt, 0);
      chk("rd_stall_cnt", bus.Stall_Cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("rd_after_pc_en", bus.PC_En, 1);
      chk("rd_after_if2id", bus.IF2ID_Flush, 0);
      chk("rd_after_halted", bus.Halted, 0);
      chk("rd_after_stall", bus.Stall_Cnt, 0);

`ifdef SINGLE_STEP_EN
      bus.Halt_Req = 1;
      tick();
      tick();
      chk("s_halted", bus.Halted, 1);
      bus.Step_Req = 1; #1;
      chk("s_req_pc_en", bus.PC_En, 0);
      tick();
      bus.Step_Req = 0; #1;
      chk("s_step_pc_en", bus.PC_En, 1);
      chk("s_step_halted", bus.Halted, 0);
      tick();
      chk("s_drain_pc_en", bus.PC_En, 0);
      chk("s_drain_halted", bus.Halted, 0);
      tick();
      chk("s_rehalted", bus.Halted, 1);
      tick();
      chk("s_stay_halted", bus.Halted, 1);
      chk("s_stay_pc_en", bus.PC_En, 0);
      bus.Halt_Req = 0;
      tick();
      bus.Step_Req = 1; #1;
      chk("s_run_pc_en", bus.PC_En, 1);
      tick();
      bus.Step_Req = 0; #1;
      chk("s_run_ignored", {bus.PC_En, bus.Halted}, 2'b10);
`endif

      // saturation of a 4-bit flush counter
      bus4.BranchTK = 1;
      for (int i = 0; i < 15; i++) tick();
      chk("sat_15", bus4.Flush_Cnt, 15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_20", bus4.Flush_Cnt, 15);
      chk("sat_if2id", bus4.IF2ID_Flush, 1);
      chk("sat_pc_en", bus4.PC_En, 1);
      bus4.BranchTK = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
